// File: rtl/dca_matrix_move_sequencer.sv
// Purpose : move-port master for a DCA matrix register; LOAD streams rows in, STORE drains rows out, CLEAR pulses init.
// Latency : LOAD sin->move_wdata_list 0 cycles; STORE move_renable->sout_valid 1 cycle; done 1 cycle after the final event.
// Backpr. : sin is ready every LOAD cycle; a one-row sout register stalls move_renable while sout is full and not taken.
//
// Ports:
//   clk, rstnn                          clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_op/cmd_num_row  command handshake (op 0 LOAD, 1 STORE, 2 CLEAR, 3 no-op)
//   sin_valid/sin_ready/sin_data        input row stream (LOAD)
//   sout_valid/sout_ready/sout_data     output row stream (STORE), sout_data registered
//   move_wenable/move_wdata_list        push row at bottom of matrix
//   move_renable/move_rdata_list        pop top row of matrix (rdata valid pre-shift)
//   init                                one-cycle matrix init strobe
//   busy, done                          activity flag, one-cycle completion pulse
module dca_matrix_move_sequencer #(
  parameter int MATRIX_SIZE_PARA = 8,
  parameter int BW_TENSOR_SCALAR = 32,
  localparam int MATRIX_NUM_ROW = MATRIX_SIZE_PARA,
  localparam int MATRIX_NUM_COL = MATRIX_SIZE_PARA,
  localparam int BW_TENSOR_ROW = MATRIX_NUM_COL * BW_TENSOR_SCALAR,
  localparam int BW_NUM_ROW = $clog2(MATRIX_NUM_ROW + 1)
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [BW_NUM_ROW-1:0]    cmd_num_row,
  input  logic                     sin_valid,
  output logic                     sin_ready,
  input  logic [BW_TENSOR_ROW-1:0] sin_data,
  output logic                     sout_valid,
  input  logic                     sout_ready,
  output logic [BW_TENSOR_ROW-1:0] sout_data,
  output logic                     move_wenable,
  output logic [BW_TENSOR_ROW-1:0] move_wdata_list,
  output logic                     move_renable,
  input  logic [BW_TENSOR_ROW-1:0] move_rdata_list,
  output logic                     init,
  output logic                     busy,
  output logic                     done
);

  localparam logic [BW_NUM_ROW-1:0] ROW_MAX = BW_NUM_ROW'(MATRIX_NUM_ROW);
  localparam logic [BW_NUM_ROW-1:0] ROW_ONE = BW_NUM_ROW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE,
    ST_DRAIN,
    ST_CLEAR
  } state_t;

  state_t                  state;
  logic [BW_NUM_ROW-1:0]   remaining;
  logic [BW_NUM_ROW-1:0]   num_row_clamped;
  logic                    cmd_hs;
  logic                    write_hs;
  logic                    read_en;
  logic                    sout_hs;

  // A zero or oversized row count means "the whole matrix".
  assign num_row_clamped = ((cmd_num_row == '0) || (cmd_num_row > ROW_MAX)) ? ROW_MAX : cmd_num_row;

  assign cmd_ready       = (state == ST_IDLE);
  assign cmd_hs          = cmd_valid & cmd_ready;
  assign busy            = (state != ST_IDLE);

  // LOAD forwards the input row straight onto the move port.
  assign sin_ready       = (state == ST_LOAD);
  assign write_hs        = sin_valid & sin_ready;
  assign move_wenable    = write_hs;
  assign move_wdata_list = write_hs ? sin_data : '0;

  // Pop only when the output register is empty or being emptied this cycle.
  assign sout_hs         = sout_valid & sout_ready;
  assign read_en         = (state == ST_STORE) & (~sout_valid | sout_ready);
  assign move_renable    = read_en;

  assign init            = (state == ST_CLEAR);

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      sout_valid <= 1'b0;
      sout_data  <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_hs) begin
            remaining <= num_row_clamped;
            case (cmd_op)
              2'd0:    state <= ST_LOAD;
              2'd1:    state <= ST_STORE;
              2'd2:    state <= ST_CLEAR;
              default: done  <= 1'b1;
            endcase
          end
        end
        ST_LOAD: begin
          if (write_hs) begin
            remaining <= remaining - ROW_ONE;
            if (remaining == ROW_ONE) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        ST_STORE: begin
          // A same-cycle read refills the register, so valid stays high.
          if (read_en) begin
            sout_data  <= move_rdata_list;
            sout_valid <= 1'b1;
            remaining  <= remaining - ROW_ONE;
            if (remaining == ROW_ONE) begin
              state <= ST_DRAIN;
            end
          end else if (sout_hs) begin
            sout_valid <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (sout_hs) begin
            sout_valid <= 1'b0;
            state      <= ST_IDLE;
            done       <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dca_matrix_move_sequencer.sv
// Directed bench for dca_matrix_move_sequencer with a behavioural 8x8 matrix register on the move port.
module tb_dca_matrix_move_sequencer;

  localparam int RW = 256;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rstnn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [3:0]    cmd_num_row;
  logic          sin_valid;
  logic          sin_ready;
  logic [RW-1:0] sin_data;
  logic          sout_valid;
  logic          sout_ready;
  logic [RW-1:0] sout_data;
  logic          move_wenable;
  logic [RW-1:0] move_wdata_list;
  logic          move_renable;
  logic [RW-1:0] move_rdata_list;
  logic          init;
  logic          busy;
  logic          done;

  int n_cmp  = 0;
  int n_fail = 0;

  int wen_cnt  = 0;
  int ren_cnt  = 0;
  int init_cnt = 0;
  int done_cnt = 0;
  int hs_cnt   = 0;
  int excl_cnt = 0;

  logic [RW-1:0] mat [NR];

  always #5 clk = ~clk;

  dca_matrix_move_sequencer dut (
    .clk             (clk),
    .rstnn           (rstnn),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_num_row     (cmd_num_row),
    .sin_valid       (sin_valid),
    .sin_ready       (sin_ready),
    .sin_data        (sin_data),
    .sout_valid      (sout_valid),
    .sout_ready      (sout_ready),
    .sout_data       (sout_data),
    .move_wenable    (move_wenable),
    .move_wdata_list (move_wdata_list),
    .move_renable    (move_renable),
    .move_rdata_list (move_rdata_list),
    .init            (init),
    .busy            (busy),
    .done            (done)
  );

  // Matrix register model: push at bottom / pop at top, both shifting up.
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < NR; i++) mat[i] <= '0;
    end else if (move_wenable) begin
      for (int i = 0; i < NR - 1; i++) mat[i] <= mat[i+1];
      mat[NR-1] <= move_wdata_list;
    end else if (move_renable) begin
      for (int i = 0; i < NR - 1; i++) mat[i] <= mat[i+1];
      mat[NR-1] <= '0;
    end
  end
  assign move_rdata_list = mat[0];

  always @(posedge clk) begin
    if (move_wenable) wen_cnt <= wen_cnt + 1;
    if (move_renable) ren_cnt <= ren_cnt + 1;
    if (init) init_cnt <= init_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (sout_valid && sout_ready) hs_cnt <= hs_cnt + 1;
    if ((int'(move_wenable) + int'(move_renable) + int'(init)) > 1) excl_cnt <= excl_cnt + 1;
  end

  function automatic logic [RW-1:0] mkrow(input logic [31:0] k);
    return {8{k ^ 32'hA5A5_0000}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstnn       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 2'd0;
    cmd_num_row = 4'd0;
    sin_valid   = 1'b0;
    sin_data    = '0;
    sout_ready  = 1'b0;

    // 1: reset state, then idle hold with no strobes
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sout_valid", sout_valid, 0);
    check("rst_sout_data", sout_data, 0);
    check("rst_sin_ready", sin_ready, 0);
    check("rst_strobes", {move_wenable, move_renable, init}, 0);
    check("rst_wdata", move_wdata_list, 0);
    rstnn = 1'b1;
    repeat (5) tick();
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_strobe_cnt", wen_cnt + ren_cnt + init_cnt + done_cnt, 0);

    // 2: LOAD num_row=0 -> 8 rows, sin_valid toggling
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_num_row = 4'd0;
    #1;
    check("t2_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      sin_valid = 1'b1;
      sin_data  = mkrow(k);
      #1;
      check("t2_wen", move_wenable, 1);
      check("t2_wdata", move_wdata_list, mkrow(k));
      tick();
      if (k < 8) begin
        sin_valid = 1'b0;
        #1;
        if (k == 1) begin
          check("t2_wen_idle", move_wenable, 0);
          check("t2_wdata_idle", move_wdata_list, 0);
          check("t2_busy", busy, 1);
        end
        tick();
      end
    end
    sin_valid = 1'b0;
    check("t2_done", done, 1);
    check("t2_busy_done", busy, 0);
    check("t2_cmd_ready_done", cmd_ready, 1);
    check("t2_wen_cnt", wen_cnt, 8);
    check("t2_mat_top", mat[0], mkrow(1));
    check("t2_mat_bot", mat[7], mkrow(8));
    tick();
    check("t2_done_low", done, 0);
    check("t2_done_cnt", done_cnt, 1);

    // 3: STORE num_row=3 with sout stalled for 4 cycles
    sout_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_num_row = 4'd3;
    tick();
    cmd_valid = 1'b0;
    #1;
    check("t3_ren_first", move_renable, 1);
    tick();
    check("t3_sout_valid", sout_valid, 1);
    check("t3_sout_row0", sout_data, mkrow(1));
    #1;
    check("t3_ren_stall", move_renable, 0);
    repeat (3) tick();
    check("t3_sout_held", sout_data, mkrow(1));
    check("t3_sout_valid_held", sout_valid, 1);
    check("t3_ren_cnt_stall", ren_cnt, 1);
    sout_ready = 1'b1;
    #1;
    check("t3_ren_resume", move_renable, 1);
    tick();
    check("t3_sout_row1", sout_data, mkrow(2));
    check("t3_sout_valid1", sout_valid, 1);
    tick();
    check("t3_sout_row2", sout_data, mkrow(3));
    check("t3_busy_drain", busy, 1);
    #1;
    check("t3_ren_drain", move_renable, 0);
    tick();
    check("t3_done", done, 1);
    check("t3_sout_valid_end", sout_valid, 0);
    check("t3_busy_end", busy, 0);
    check("t3_ren_cnt", ren_cnt, 3);
    check("t3_hs_cnt", hs_cnt, 3);
    sout_ready = 1'b0;
    tick();

    // 4: CLEAR then reserved op
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_num_row = 4'd0;
    tick();
    cmd_valid = 1'b0;
    #1;
    check("t4_init", init, 1);
    check("t4_busy", busy, 1);
    tick();
    check("t4_init_low", init, 0);
    check("t4_clear_done", done, 1);
    check("t4_init_cnt", init_cnt, 1);
    tick();
    cmd_valid = 1'b1; cmd_op = 2'd3;
    tick();
    cmd_valid = 1'b0;
    check("t4_op3_done", done, 1);
    check("t4_op3_busy", busy, 0);
    check("t4_op3_strobes", wen_cnt + ren_cnt + init_cnt, 12);
    tick();
    check("t4_op3_done_low", done, 0);
    check("t4_done_cnt", done_cnt, 4);

    // 5: reset during STORE after two reads
    sout_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_num_row = 4'd0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("t5_ren_before", ren_cnt, 5);
    rstnn = 1'b0;
    #1;
    check("t5_sout_valid", sout_valid, 0);
    check("t5_sout_data", sout_data, 0);
    check("t5_busy", busy, 0);
    check("t5_ren", move_renable, 0);
    tick();
    tick();
    rstnn = 1'b1;
    tick();
    tick();
    check("t5_ren_after", ren_cnt, 5);
    check("t5_done_cnt", done_cnt, 4);
    check("t5_sout_valid_after", sout_valid, 0);

    // 6: cmd_valid held across LOAD num_row=2, STORE accepted in done cycle
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_num_row = 4'd2;
    #1;
    check("t6_cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_op = 2'd1; cmd_num_row = 4'd1;
    sin_valid = 1'b1; sin_data = mkrow(21);
    #1;
    check("t6_cmd_ready_busy0", cmd_ready, 0);
    tick();
    sin_data = mkrow(22);
    #1;
    check("t6_cmd_ready_busy1", cmd_ready, 0);
    check("t6_wen", move_wenable, 1);
    tick();
    sin_valid = 1'b0;
    check("t6_done", done, 1);
    check("t6_cmd_ready_done", cmd_ready, 1);
    check("t6_mat_bot", mat[7], mkrow(22));
    tick();
    cmd_valid = 1'b0;
    check("t6_store_busy", busy, 1);
    check("t6_done_low", done, 0);
    check("t6_wen_cnt", wen_cnt, 10);
    #1;
    check("t6_store_ren", move_renable, 1);
    tick();
    check("t6_sout_valid", sout_valid, 1);
    tick();
    check("t6_store_done", done, 1);
    check("t6_sout_valid_end", sout_valid, 0);
    tick();
    check("t6_done_cnt", done_cnt, 6);
    check("t6_ren_cnt", ren_cnt, 6);
    check("excl_violations", excl_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
